// File: rtl/ift_stim_sequencer_pkg.sv
// Purpose : shared types and entry layout for the IFT stimulus sequencer.
// Latency : n/a (package only).
// Backpress: n/a.
//
// Holds the default geometry (N_IN, TAINT_W, TIME_W, DEPTH), the bit offsets
// of each field inside a packed table entry, the sequencer state enum, and
// helpers that unpack an entry and turn a dwell field into a counter preload.
// Entry packing, MSB first: {data[N_IN-1:0], taint[N_IN-1] .. taint[0], dwell}.
package ift_stim_pkg;

  localparam int IFT_N_IN    = 2;
  localparam int IFT_TAINT_W = 32;
  localparam int IFT_TIME_W  = 16;
  localparam int IFT_DEPTH   = 16;

  // Field layout inside one table entry.
  localparam int DWELL_LSB   = 0;
  localparam int TAINT_LSB   = DWELL_LSB + IFT_TIME_W;
  localparam int TAINT_TOT_W = IFT_N_IN * IFT_TAINT_W;
  localparam int DATA_LSB    = TAINT_LSB + TAINT_TOT_W;
  localparam int IFT_ENTRY_W = DATA_LSB + IFT_N_IN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [IFT_N_IN-1:0]    data;
    logic [TAINT_TOT_W-1:0] taint;   // taint[i] lives at [i*TAINT_W +: TAINT_W]
    logic [IFT_TIME_W-1:0]  dwell;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [IFT_ENTRY_W-1:0] raw);
    entry_t e;
    e.data  = raw[DATA_LSB  +: IFT_N_IN];
    e.taint = raw[TAINT_LSB +: TAINT_TOT_W];
    e.dwell = raw[DWELL_LSB +: IFT_TIME_W];
    return e;
  endfunction

  // A dwell of 0 still holds the entry for one cycle, so the counter preload
  // is max(dwell,1)-1.
  function automatic logic [IFT_TIME_W-1:0] hold_preload(input logic [IFT_TIME_W-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - 1'b1;
  endfunction

endpackage

// File: rtl/ift_stim_sequencer_if.sv
// Purpose : config + stimulus bundle between a config master and the sequencer.
// Latency : n/a (wires only).
// Backpress: none; config writes are strobes, rejected writes flagged by cfg_err.
//
// Signals:
//   cfg_we/cfg_addr/cfg_wdata  table write port
//   cfg_len_we/cfg_len         entry-count write port (1..DEPTH)
//   start/stop/loop            sequence control
//   dut_data/dut_taint         stimulus driven into the DUT under test
//   stim_valid/busy/done       sequencer status
//   cfg_err                    one-cycle pulse on a rejected write or start
//   cur_idx                    index of the entry currently applied
//   obs_taint/obs_acc          observed DUT taint and its accumulated OR
// modport master = bench / config master side, slave = sequencer side.
interface ift_stim_sequencer_if
  import ift_stim_pkg::*;
#(
  parameter int N_IN    = IFT_N_IN,
  parameter int TAINT_W = IFT_TAINT_W,
  parameter int TIME_W  = IFT_TIME_W,
  parameter int DEPTH   = IFT_DEPTH
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENTRY_W = N_IN + N_IN * TAINT_W + TIME_W;

  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_addr;
  logic [ENTRY_W-1:0]      cfg_wdata;
  logic                    cfg_len_we;
  logic [IDX_W:0]          cfg_len;
  logic                    start;
  logic                    stop;
  logic                    loop;
  logic [N_IN-1:0]         dut_data;
  logic [N_IN*TAINT_W-1:0] dut_taint;
  logic                    stim_valid;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;
  logic [IDX_W-1:0]        cur_idx;
  logic [TAINT_W-1:0]      obs_taint;
  logic [TAINT_W-1:0]      obs_acc;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_len_we, cfg_len,
    output start, stop, loop, obs_taint,
    input  dut_data, dut_taint, stim_valid, busy, done, cfg_err, cur_idx, obs_acc
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_len_we, cfg_len,
    input  start, stop, loop, obs_taint,
    output dut_data, dut_taint, stim_valid, busy, done, cfg_err, cur_idx, obs_acc
  );

endinterface

// File: rtl/ift_stim_sequencer_dwell_timer.sv
// Purpose : loadable TIME_W-bit down-counter that marks the last dwell cycle.
// Latency : expire_o reflects the registered count (1 cycle after load_i).
// Backpress: none; load_i always wins over counting.
//
// Ports: clk, rst (sync, active-high), load_i/value_i preload, expire_o high
// while the count is 0. The count parks at 0 rather than wrapping.
module ift_dwell_timer #(
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [TIME_W-1:0] value_i,
  output logic              expire_o
);

  logic [TIME_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ift_stim_sequencer.sv
// Purpose : replays a programmed table of {data, taint, dwell} entries into a DUT.
// Latency : start -> entry 0 on the outputs 1 cycle later; entries back to back.
// Backpress: none; config writes while running are dropped and flagged on cfg_err.
//
// Ports: clk, rst (synchronous, active-high) plus the slave side of
// ift_stim_sequencer_if (config/table writes, start/stop/loop, stimulus and
// status outputs, obs_taint/obs_acc). All outputs are registered.
// Optional feature macro IFT_STIM_OBSERVE_EN: when defined, obs_acc ORs in
// obs_taint on the final cycle of every entry; otherwise obs_acc is 0.
// Geometry parameters must match the ift_stim_pkg defaults, since the entry
// layout helpers live in the package.
module ift_stim_sequencer
  import ift_stim_pkg::*;
#(
  parameter int N_IN    = IFT_N_IN,
  parameter int TAINT_W = IFT_TAINT_W,
  parameter int TIME_W  = IFT_TIME_W,
  parameter int DEPTH   = IFT_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  ift_stim_sequencer_if.slave io
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LEN_W   = IDX_W + 1;
  localparam int ENTRY_W = N_IN + N_IN * TAINT_W + TIME_W;

  // ---------------------------------------------------------------- state
  seq_state_e              state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [N_IN-1:0]         data_q;
  logic [N_IN*TAINT_W-1:0] taint_q;
  logic                    vld_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [LEN_W-1:0]        len_q;

  // Table storage: intentionally not reset so contents survive rst.
  logic [ENTRY_W-1:0]      tbl_q [DEPTH];

  // ---------------------------------------------------------------- decode
  logic             to_idle;
  logic             start_go;
  logic             start_err;
  logic             adv_go;
  logic             finish_go;
  logic [IDX_W-1:0] idx_d;
  logic [LEN_W-1:0] len_m1;
  logic [IDX_W-1:0] last_idx;
  logic             len_ok;
  logic             cfg_req;
  logic             cfg_ok;
  entry_t           nxt_entry;
  logic             tmr_load;
  logic [TIME_W-1:0] tmr_value;
  logic             tmr_expire;

  assign len_m1   = len_q - 1'b1;
  assign last_idx = len_m1[IDX_W-1:0];
  assign len_ok   = (io.cfg_len != '0) && (io.cfg_len <= LEN_W'(DEPTH));
  assign cfg_req  = io.cfg_we || io.cfg_len_we;
  // A bad length poisons the whole cycle's write, including a paired table write.
  assign cfg_ok   = (state_q != ST_RUN) && !(io.cfg_len_we && !len_ok);

  always_comb begin
    to_idle   = 1'b0;
    start_go  = 1'b0;
    start_err = 1'b0;
    adv_go    = 1'b0;
    finish_go = 1'b0;
    idx_d     = idx_q;
    // stop outranks both start and an entry advance in the same cycle
    if (io.stop && (state_q != ST_IDLE)) begin
      to_idle = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (tmr_expire) begin
        if (idx_q == last_idx) begin
          // loop only matters at the last-entry boundary
          if (io.loop) begin
            adv_go = 1'b1;
            idx_d  = '0;
          end else begin
            finish_go = 1'b1;
          end
        end else begin
          adv_go = 1'b1;
          idx_d  = idx_q + 1'b1;
        end
      end
    end else if (io.start) begin
      if (len_q != '0) begin
        start_go = 1'b1;
        idx_d    = '0;
      end else begin
        start_err = 1'b1;
      end
    end
  end

  assign nxt_entry = unpack_entry(tbl_q[idx_d]);
  assign tmr_load  = start_go || adv_go;
  assign tmr_value = hold_preload(nxt_entry.dwell);

  ift_dwell_timer #(
    .TIME_W (TIME_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  // ---------------------------------------------------------------- table
  always_ff @(posedge clk) begin
    if (io.cfg_we && cfg_ok) begin
      tbl_q[io.cfg_addr] <= io.cfg_wdata;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      taint_q <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      err_q <= (cfg_req && !cfg_ok) || start_err;
      if (io.cfg_len_we && cfg_ok) begin
        len_q <= io.cfg_len;
      end
      if (to_idle) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        data_q  <= '0;
        taint_q <= '0;
        vld_q   <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (start_go || adv_go) begin
        state_q <= ST_RUN;
        idx_q   <= idx_d;
        data_q  <= nxt_entry.data;
        taint_q <= nxt_entry.taint;
        vld_q   <= 1'b1;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (finish_go) begin
        // last entry stays on the outputs while parked in DONE
        state_q <= ST_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- observe
`ifdef IFT_STIM_OBSERVE_EN
  logic [TAINT_W-1:0] obs_acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      obs_acc_q <= '0;
    end else if (start_go) begin
      obs_acc_q <= '0;
    end else if ((state_q == ST_RUN) && tmr_expire) begin
      obs_acc_q <= obs_acc_q | io.obs_taint;
    end
  end

  assign io.obs_acc = obs_acc_q;
`else
  logic unused_obs_taint;
  assign unused_obs_taint = ^io.obs_taint;
  assign io.obs_acc       = '0;
`endif

  // ---------------------------------------------------------------- outputs
  assign io.dut_data   = data_q;
  assign io.dut_taint  = taint_q;
  assign io.stim_valid = vld_q;
  assign io.busy       = busy_q;
  assign io.done       = done_q;
  assign io.cfg_err    = err_q;
  assign io.cur_idx    = idx_q;

endmodule

// File: tb/tb_ift_stim_sequencer.sv
// Purpose : self-checking bench for ift_stim_sequencer.
// Latency : n/a.
// Backpress: n/a.
//
// The expected stimulus at cycle k after a start is derived from the table
// alone: each entry occupies max(dwell,1) consecutive cycles, the sequence
// repeats when looping, and otherwise the last entry is held with done=1.
module tb_ift_stim_sequencer;

  typedef struct {
    logic [1:0]  data;   // data[0] = a, data[1] = b
    logic [31:0] t0;     // a_t
    logic [31:0] t1;     // b_t
    logic [15:0] d;
  } tb_ent_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  tb_ent_t tb_tbl [16];

  ift_stim_sequencer_if bus ();

  ift_stim_sequencer dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hold(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  task automatic set_ent(input int i, input logic [1:0] data, input logic [31:0] t0,
                         input logic [31:0] t1, input logic [15:0] d);
    tb_tbl[i].data = data;
    tb_tbl[i].t0   = t0;
    tb_tbl[i].t1   = t1;
    tb_tbl[i].d    = d;
  endtask

  task automatic write_entry(input int i);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'(i);
    bus.cfg_wdata = {tb_tbl[i].data, tb_tbl[i].t1, tb_tbl[i].t0, tb_tbl[i].d};
    tick();
    bus.cfg_we = 1'b0;
    check("wr_err", 128'(bus.cfg_err), 128'(0));
  endtask

  task automatic write_len(input int n, input bit exp_err);
    bus.cfg_len_we = 1'b1;
    bus.cfg_len    = 5'(n);
    tick();
    bus.cfg_len_we = 1'b0;
    check("len_err", 128'(bus.cfg_err), 128'(exp_err));
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"},   128'(bus.stim_valid), 128'(0));
    check({tag, "_busy"},  128'(bus.busy),       128'(0));
    check({tag, "_done"},  128'(bus.done),       128'(0));
    check({tag, "_idx"},   128'(bus.cur_idx),    128'(0));
    check({tag, "_data"},  128'(bus.dut_data),   128'(0));
    check({tag, "_taint"}, 128'(bus.dut_taint),  128'(0));
  endtask

  // Checks cycles k0..k1 after a start (cycle 1 = first cycle entry 0 shows).
  // The current time must already be cycle k0; returns at cycle k1.
  task automatic run_check(input int len, input bit lp, input int k0, input int k1);
    int total;
    total = 0;
    for (int i = 0; i < len; i++) total += hold(tb_tbl[i].d);
    for (int k = k0; k <= k1; k++) begin
      int off;
      int idx;
      bit fin;
      off = k - 1;
      fin = 1'b0;
      if (lp) off = off % total;
      else if (off >= total) begin
        fin = 1'b1;
        off = total - 1;
      end
      idx = 0;
      while (off >= hold(tb_tbl[idx].d)) begin
        off -= hold(tb_tbl[idx].d);
        idx++;
      end
      check("run_idx",   128'(bus.cur_idx),    128'(idx));
      check("run_vld",   128'(bus.stim_valid), 128'(1));
      check("run_busy",  128'(bus.busy),       128'(!fin));
      check("run_done",  128'(bus.done),       128'(fin));
      check("run_data",  128'(bus.dut_data),   128'(tb_tbl[idx].data));
      check("run_taint", 128'(bus.dut_taint),  128'({tb_tbl[idx].t1, tb_tbl[idx].t0}));
      if (k < k1) tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_wdata  = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.loop       = 1'b0;
    bus.obs_taint  = '0;

    // ---- reset state
    tick();
    tick();
    check_idle("reset");
    check("reset_err", 128'(bus.cfg_err), 128'(0));
    check("reset_obs", 128'(bus.obs_acc), 128'(0));
    rst = 1'b0;
    tick();

    // ---- four directed entries, dwell 8, no loop
    set_ent(0, 2'b00, 32'h0,        32'h0,        16'd8);
    set_ent(1, 2'b10, 32'h0,        32'hFFFFFFFF, 16'd8);
    set_ent(2, 2'b01, 32'h1,        32'h0,        16'd8);
    set_ent(3, 2'b11, 32'h80000000, 32'h1,        16'd8);
    for (int i = 0; i < 4; i++) write_entry(i);
    write_len(4, 1'b0);
    do_start();
    run_check(4, 1'b0, 1, 34);

    // ---- dwell 0/1/3 mixed, restarted from DONE
    set_ent(0, 2'b01, 32'hA5A5A5A5, 32'h5A5A5A5A, 16'd0);
    set_ent(1, 2'b10, 32'h12345678, 32'h9ABCDEF0, 16'd1);
    set_ent(2, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 16'd3);
    for (int i = 0; i < 3; i++) write_entry(i);
    write_len(3, 1'b0);
    do_start();
    run_check(3, 1'b0, 1, 8);

    // ---- len=2 looping, dwell 2; then stop on an advance cycle
    set_ent(0, 2'($urandom()), $urandom(), $urandom(), 16'd2);
    set_ent(1, 2'($urandom()), $urandom(), $urandom(), 16'd2);
    for (int i = 0; i < 2; i++) write_entry(i);
    write_len(2, 1'b0);
    bus.loop = 1'b1;
    do_start();
    run_check(2, 1'b1, 1, 20);
    // cycle 20 is the last cycle of entry 1, so an advance coincides with stop
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    check_idle("stop");

    // ---- config write during RUN is rejected
    do_start();
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd0;
    bus.cfg_wdata = ~{tb_tbl[0].data, tb_tbl[0].t1, tb_tbl[0].t0, tb_tbl[0].d};
    run_check(2, 1'b0, 1, 1);
    tick();
    bus.cfg_we = 1'b0;
    check("run_wr_err", 128'(bus.cfg_err), 128'(1));
    run_check(2, 1'b0, 2, 2);
    tick();
    check("run_wr_err_clr", 128'(bus.cfg_err), 128'(0));
    run_check(2, 1'b0, 3, 6);
    // bad lengths in DONE are rejected; the old length/table still replay
    write_len(0, 1'b1);
    write_len(17, 1'b1);
    do_start();
    run_check(2, 1'b0, 1, 6);

    // ---- reset mid-RUN, then start with len=0, then table retained
    do_start();
    run_check(2, 1'b0, 1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_run");
    check("rst_run_err", 128'(bus.cfg_err), 128'(0));
    do_start();
    check("len0_start_err", 128'(bus.cfg_err), 128'(1));
    check_idle("len0_start");
    tick();
    check("len0_err_clr", 128'(bus.cfg_err), 128'(0));
    write_len(2, 1'b0);
    do_start();
    run_check(2, 1'b0, 1, 6);

    // ---- randomized tables
    for (int it = 0; it < 4; it++) begin
      int len;
      int total;
      bit lp;
      len = int'($urandom_range(1, 16));
      lp  = 1'($urandom());
      total = 0;
      for (int i = 0; i < len; i++) begin
        set_ent(i, 2'($urandom()), $urandom(), $urandom(), 16'($urandom_range(0, 3)));
        total += hold(tb_tbl[i].d);
        write_entry(i);
      end
      write_len(len, 1'b0);
      bus.loop = lp;
      do_start();
      run_check(len, lp, 1, lp ? 2 * total + 1 : total + 3);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.loop = 1'b0;
      check_idle("rand_stop");
    end

`ifdef IFT_STIM_OBSERVE_EN
    // ---- observed taint accumulation
    set_ent(0, 2'b01, 32'h1, 32'h2, 16'd2);
    set_ent(1, 2'b10, 32'h3, 32'h4, 16'd2);
    for (int i = 0; i < 2; i++) write_entry(i);
    write_len(2, 1'b0);
    bus.obs_taint = 32'h0F;
    do_start();
    check("obs_c1", 128'(bus.obs_acc), 128'(0));
    tick();
    tick();
    check("obs_c3", 128'(bus.obs_acc), 128'(32'h0F));
    bus.obs_taint = 32'hF0;
    tick();
    tick();
    check("obs_done", 128'(bus.done), 128'(1));
    check("obs_acc", 128'(bus.obs_acc), 128'(32'hFF));
    bus.obs_taint = 32'hF00;
    tick();
    check("obs_hold", 128'(bus.obs_acc), 128'(32'hFF));
    bus.obs_taint = 32'h0;
    do_start();
    check("obs_clr", 128'(bus.obs_acc), 128'(0));
`else
    check("obs_off", 128'(bus.obs_acc), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ift_stim_sequencer.md
Name: ift_stim_sequencer

Overview:
- Synthesizable stimulus scheduler for IFT hierarchy test harnesses.
- Replays a programmed table of entries into a DUT's data inputs and 32-bit taint vectors, for example a, a_t, b, b_t of the hierarchy DUT.
- Each entry is held for a programmed dwell time in cycles.
- Replaces ad-hoc delay-driven bench loops with a clocked, reproducible sequencer that a bench or on-chip config master can program.

Parameters:
- N_IN, 2, number of DUT data inputs sequenced; each has 1 data bit and one taint vector.
- TAINT_W, 32, width of each taint vector.
- TIME_W, 16, dwell field width in cycles.
- DEPTH, 16, table entries; power of two.
- ENTRY_W, N_IN + N_IN*TAINT_W + TIME_W, derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(DEPTH)  table write address.
- cfg_wdata  in  ENTRY_W  entry, packed as {data[N_IN-1:0], taint[N_IN-1]..taint[0], dwell}.
- cfg_len_we  in  1  write strobe for the entry count.
- cfg_len  in  $clog2(DEPTH)+1  number of entries, 1..DEPTH.
- start  in  1  begin the sequence (pulse).
- stop  in  1  abort the sequence (pulse).
- loop  in  1  wrap to entry 0 after the last entry instead of finishing.
- dut_data  out  N_IN  data bits driven to the DUT.
- dut_taint  out  N_IN*TAINT_W  concatenated taint vectors driven to the DUT.
- stim_valid  out  1  outputs carry a table entry.
- busy  out  1  sequencer is in RUN.
- done  out  1  sticky sequence-complete flag.
- cfg_err  out  1  one-cycle pulse on a rejected config write.
- cur_idx  out  $clog2(DEPTH)  index of the entry currently applied.
- obs_taint  in  TAINT_W  DUT output taint, for example c_t; used only under the macro.
- obs_acc  out  TAINT_W  accumulated observed taint.

Behaviour:
- Reset: all outputs 0; len register = 0; table contents are not reset. State goes to IDLE.
- States: IDLE, RUN, DONE.
  - IDLE: start with len != 0 -> RUN. Next cycle: cur_idx=0, entry 0 on the outputs, stim_valid=1, busy=1. Latency is exactly 1 cycle.
  - IDLE: start with len == 0 -> cfg_err pulse, stay IDLE.
- RUN, dwell:
  - Each entry is held exactly max(dwell,1) cycles; dwell=0 is treated as 1.
  - Down-counter loads dwell-1 on entry, decrements each cycle, advances the entry at 0.
- RUN, entry advance:
  - Not the last entry (cur_idx != len-1): next entry appears the following cycle, no gap cycle.
  - Last entry, loop=1: wrap to entry 0 with no gap.
  - Last entry, loop=0: -> DONE.
  - loop is sampled only at the last-entry boundary.
- DONE:
  - busy=0, done=1.
  - stim_valid stays 1 and the last entry stays applied.
  - start -> clear done, restart at entry 0 (same latency as from IDLE).
- stop in RUN or DONE: -> IDLE next cycle, outputs zeroed, done cleared. stop has priority over start and over entry advance in the same cycle.
- Config writes:
  - Writes while busy are ignored and cfg_err pulses.
  - Writes in IDLE/DONE take effect the next cycle.
  - cfg_len of 0 or >DEPTH is rejected with a cfg_err pulse.
- rst asserted mid-RUN returns to reset values on the next edge; the table keeps its contents.
- All outputs are registered.

Optional Feature:
- Macro: IFT_STIM_OBSERVE_EN.
- Enabled:
  - On the final cycle of each entry's dwell, obs_acc <= obs_acc | obs_taint.
  - obs_acc clears on start and on rst.
  - Holds its value in DONE/IDLE.
- Disabled: obs_acc tied to 0; obs_taint unused.

Decomposition:
- Package ift_stim_pkg:
  - State enum (IDLE/RUN/DONE).
  - Entry field offset/width localparams derived from N_IN, TAINT_W, TIME_W.
  - Function unpacking an entry into data/taint/dwell.
- One sub-module: ift_dwell_timer.
  - Loadable down-counter of TIME_W bits.
  - Inputs load and value; output expire.

Test Plan:
- Program 4 entries: {a=0,b=0,a_t=0,b_t=0,d=8}, {0,1,0,0xFFFFFFFF,8}, {1,0,0x1,0,8}, {1,1,0x80000000,0x1,8}; len=4, loop=0, start at cycle 0 -> each entry valid for 8 cycles starting cycle 1; done=1 at cycle 33; last entry held.
- dwell=0 and dwell=1 entries mixed with dwell=3 -> holds of 1,1,3 cycles; no gap cycles.
- len=2, loop=1, dwell=2 each -> cur_idx sequence 0,0,1,1,0,0,... for 20 cycles; done never set.
- stop asserted in the same cycle as an entry advance -> IDLE next cycle, outputs 0, done=0. Also: rst mid-RUN -> all outputs 0.
- cfg_we during RUN, plus cfg_len=0 in IDLE -> cfg_err pulse each time, table/len unchanged; start with len=0 -> cfg_err, stays IDLE.
- With IFT_STIM_OBSERVE_EN: obs_taint = 0x0F then 0xF0 at dwell ends -> obs_acc=0xFF; obs_acc clears on the next start.
